// File: rtl/jt12_pkg.sv
// Shared definitions for the YM2612-style frequency sequencer.
// Holds register address constants, slot/channel counts, operator order
// encoding, the high-byte latch layout and small slot arithmetic helpers.
package jt12_pkg;

  localparam int SLOTS    = 24;
  localparam int CHANNELS = 6;
  localparam int CH3_OPS  = 3;

  localparam logic [7:0] REG_CH3MODE = 8'h27;
  localparam logic [7:0] REG_DTMUL   = 8'h30;  // 0x30-0x3F
  localparam logic [7:0] REG_FNUM_LO = 8'hA0;  // 0xA0-0xA2
  localparam logic [7:0] REG_FNUM_HI = 8'hA4;  // 0xA4-0xA6
  localparam logic [7:0] REG_CH3_LO  = 8'hA8;  // 0xA8-0xAA
  localparam logic [7:0] REG_CH3_HI  = 8'hAC;  // 0xAC-0xAE

  // Operator order inside the 24-slot frame; matches reg 0x3x bits [3:2].
  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S3 = 2'd1,
    OP_S2 = 2'd2,
    OP_S4 = 2'd3
  } op_e;

  // Content of the 0xA4/0xAC style high latches.
  typedef struct packed {
    logic [2:0] block;
    logic [2:0] fnum_hi;
  } hi_latch_t;

  // Operator group of a slot (slot = op*6 + ch).
  function automatic logic [1:0] slot_op(input logic [4:0] s);
    if (s >= 5'd18) return 2'd3;
    if (s >= 5'd12) return 2'd2;
    if (s >= 5'd6)  return 2'd1;
    return 2'd0;
  endfunction

  // Channel of a slot.
  function automatic logic [2:0] slot_ch(input logic [4:0] s);
    logic [4:0] base;
    base = 5'(slot_op(s)) * 5'd6;
    return 3'(s - base);
  endfunction

  function automatic logic [4:0] slot_index(input logic [1:0] op, input logic [2:0] ch);
    return 5'(op) * 5'd6 + 5'(ch);
  endfunction

  // CH3 per-operator registers are not in slot order: A9->S1, A8->S3, AA->S2.
  function automatic logic [1:0] ch3_op(input logic [1:0] sel);
    case (sel)
      2'd1:    return OP_S1;
      2'd0:    return OP_S3;
      default: return OP_S2;
    endcase
  endfunction

endpackage

// File: rtl/jt12_freq_seq_if.sv
// CPU write bus of the frequency sequencer.
//   cpu_din  : write data / register address
//   cpu_addr : bit0 0=address 1=data, bit1 part (0=I, 1=II)
//   cpu_wr   : single-clk write strobe
//   busy     : write-busy flag returned to the CPU
interface jt12_freq_seq_if;
  logic [7:0] cpu_din;
  logic [1:0] cpu_addr;
  logic       cpu_wr;
  logic       busy;

  modport master (output cpu_din, cpu_addr, cpu_wr, input busy);
  modport slave  (input cpu_din, cpu_addr, cpu_wr, output busy);
endinterface

// File: rtl/jt12_freq_regs.sv
// Write decoder and storage for channel fnum/block, CH3 per-operator
// fnum/block and per-slot DT1/MUL. A data strobe is captured together with
// the address it refers to and committed on the following clk edge.
// Two combinational read ports: one for the stage-I values, one for MUL.
//   i_din/i_addr/i_wr : CPU bus
//   i_rd_slot         : slot whose fnum/block/dt1 are read
//   i_mul_slot        : slot whose mul is read
//   o_*               : read data, o_ch3_mode = channel-3 special mode
module jt12_freq_regs
  import jt12_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_din,
  input  logic [1:0]  i_addr,
  input  logic        i_wr,
  input  logic [4:0]  i_rd_slot,
  input  logic [4:0]  i_mul_slot,
  output logic [10:0] o_fnum,
  output logic [2:0]  o_block,
  output logic [2:0]  o_dt1,
  output logic [3:0]  o_mul,
  output logic        o_ch3_mode
);

  logic [7:0]  r_addr;
  logic        r_part;
  logic        r_pend;
  logic [7:0]  r_pend_addr;
  logic [7:0]  r_pend_din;
  logic        r_pend_part;
  hi_latch_t   r_hi;
  hi_latch_t   r_ch3_hi;
  logic        r_ch3_mode;
  logic [10:0] r_fnum      [CHANNELS];
  logic [2:0]  r_block     [CHANNELS];
  logic [10:0] r_ch3_fnum  [CH3_OPS];
  logic [2:0]  r_ch3_block [CH3_OPS];
  logic [2:0]  r_dt1       [SLOTS];
  logic [3:0]  r_mul       [SLOTS];

  logic [1:0]  w_sel;
  logic [2:0]  w_ch;
  logic        w_valid_ch;
  logic [4:0]  w_dm_idx;
  logic [1:0]  w_c3_op;
  logic        w_we_dtmul, w_we_hi, w_we_fnum, w_we_c3hi, w_we_c3, w_we_mode;
  logic [1:0]  w_rd_op;
  logic [2:0]  w_rd_ch;

  // Capture stage: address register and the pending data write. A part
  // mismatch drops the write here so the commit stage never sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_part      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_din  <= '0;
      r_pend_part <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_pend <= i_wr & i_addr[0] & (i_addr[1] == r_part);
      if (i_wr && !i_addr[0]) begin
        r_addr <= i_din;
        r_part <= i_addr[1];
      end
      if (i_wr && i_addr[0]) begin
        r_pend_addr <= r_addr;
        r_pend_din  <= i_din;
        r_pend_part <= r_part;
      end
    end
  end

  // Commit-stage decode of the pending write.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    w_we_dtmul = 1'b0;
    w_we_hi    = 1'b0;
    w_we_fnum  = 1'b0;
    w_we_c3hi  = 1'b0;
    w_we_c3    = 1'b0;
    w_we_mode  = 1'b0;
    w_sel      = r_pend_addr[1:0];
    w_valid_ch = (w_sel != 2'd3);
    w_ch       = r_pend_part ? 3'd3 + {1'b0, w_sel} : {1'b0, w_sel};
    w_dm_idx   = slot_index(r_pend_addr[3:2], w_ch);
    w_c3_op    = ch3_op(w_sel);
    if (r_pend) begin
      if (r_pend_addr[7:4] == REG_DTMUL[7:4])        w_we_dtmul = w_valid_ch;
      else if (r_pend_addr[7:2] == REG_FNUM_HI[7:2]) w_we_hi    = w_valid_ch;
      else if (r_pend_addr[7:2] == REG_FNUM_LO[7:2]) w_we_fnum  = w_valid_ch;
      else if (r_pend_addr[7:2] == REG_CH3_HI[7:2])  w_we_c3hi  = w_valid_ch & ~r_pend_part;
      else if (r_pend_addr[7:2] == REG_CH3_LO[7:2])  w_we_c3    = w_valid_ch & ~r_pend_part;
      else if (r_pend_addr == REG_CH3MODE)           w_we_mode  = ~r_pend_part;
    end
  end

  // Storage. Reads happen in the same edge as commits, so a read of the
  // entry being written returns its old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the arrays are small flop banks that must read as zero after
      // reset, so they are cleared here rather than left as uninitialised RAM.
      for (int i = 0; i < CHANNELS; i++) begin
        r_fnum[i]  <= '0;
        r_block[i] <= '0;
      end
      for (int i = 0; i < CH3_OPS; i++) begin
        r_ch3_fnum[i]  <= '0;
        r_ch3_block[i] <= '0;
      end
      for (int i = 0; i < SLOTS; i++) begin
        r_dt1[i] <= '0;
        r_mul[i] <= '0;
      end
      r_hi       <= '0;
      r_ch3_hi   <= '0;
      r_ch3_mode <= 1'b0;
    end else begin
      if (w_we_dtmul) begin
        r_dt1[w_dm_idx] <= r_pend_din[6:4];
        r_mul[w_dm_idx] <= r_pend_din[3:0];
      end
      if (w_we_hi)   r_hi     <= r_pend_din[5:0];
      if (w_we_c3hi) r_ch3_hi <= r_pend_din[5:0];
      if (w_we_fnum) begin
        r_fnum[w_ch]  <= {r_hi.fnum_hi, r_pend_din};
        r_block[w_ch] <= r_hi.block;
      end
      if (w_we_c3) begin
        r_ch3_fnum[w_c3_op]  <= {r_ch3_hi.fnum_hi, r_pend_din};
        r_ch3_block[w_c3_op] <= r_ch3_hi.block;
      end
      if (w_we_mode) r_ch3_mode <= r_pend_din[6];
    end
  end

  // Read ports. Channel 2 in special mode takes per-operator values for
  // S1/S3/S2; S4 always uses the normal channel-2 entry.
  always_comb begin
    w_rd_op = slot_op(i_rd_slot);
    w_rd_ch = slot_ch(i_rd_slot);
    o_fnum  = r_fnum[w_rd_ch];
    o_block = r_block[w_rd_ch];
    if (r_ch3_mode && w_rd_ch == 3'd2 && w_rd_op != OP_S4) begin
      o_fnum  = r_ch3_fnum[w_rd_op];
      o_block = r_ch3_block[w_rd_op];
    end
    o_dt1 = r_dt1[i_rd_slot];
    o_mul = r_mul[i_mul_slot];
  end

  assign o_ch3_mode = r_ch3_mode;

endmodule

// File: rtl/jt12_freq_seq.sv
// Frequency sequencer top: decodes CPU frequency/operator writes and replays
// them in 24-slot order for the phase generator.
//   clk, rst_n : clock, async active-low reset
//   clk_en     : slot-advance enable
//   bus        : CPU write bus (din, addr, wr, busy)
//   slot       : current slot (stage I)
//   ch3_mode   : channel-3 special mode flag
//   fnum_I, block_I, dt1_I : stage-I values of the current slot
//   mul_II     : multiplier of the previous slot
module jt12_freq_seq
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  jt12_freq_seq_if.slave        bus,
  output logic [4:0]            slot,
  output logic                  ch3_mode,
  output logic [10:0]           fnum_I,
  output logic [2:0]            block_I,
  output logic [2:0]            dt1_I,
  output logic [3:0]            mul_II
);

  localparam int BW = $clog2(BUSY_CYCLES + 1);

  logic [BW-1:0] r_busy_cnt;
  logic [4:0]    w_slot_nxt;
  logic          w_data_wr;
  logic [10:0]   w_fnum;
  logic [2:0]    w_block;
  logic [2:0]    w_dt1;
  logic [3:0]    w_mul;

  assign w_slot_nxt = (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
  assign w_data_wr  = bus.cpu_wr & bus.cpu_addr[0];

  // Stage-I values are read for the slot being entered; mul is read for the
  // slot being left, which yields the one-tick stage-II delay.
  jt12_freq_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_din      (bus.cpu_din),
    .i_addr     (bus.cpu_addr),
    .i_wr       (bus.cpu_wr),
    .i_rd_slot  (w_slot_nxt),
    .i_mul_slot (slot),
    .o_fnum     (w_fnum),
    .o_block    (w_block),
    .o_dt1      (w_dt1),
    .o_mul      (w_mul),
    .o_ch3_mode (ch3_mode)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      fnum_I  <= '0;
      block_I <= '0;
      dt1_I   <= '0;
      mul_II  <= '0;
    end else if (clk_en) begin
      slot    <= w_slot_nxt;
      fnum_I  <= w_fnum;
      block_I <= w_block;
      dt1_I   <= w_dt1;
      mul_II  <= w_mul;
    end
  end

  // A new data write reloads the counter even if it is still running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else if (w_data_wr) begin
      r_busy_cnt <= BW'(BUSY_CYCLES);
    end else if (clk_en && r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - BW'(1);
    end
  end

  assign bus.busy = (r_busy_cnt != '0);

endmodule

// File: doc/jt12_freq_seq.md
Name: jt12_freq_seq

Overview:
- CPU-side writer that feeds the phase generator: decodes YM2612-style register writes for frequency and operator tuning.
- Stores 6-channel fnum/block and 24-operator DT1/MUL values, including channel-3 special mode.
- Replays them slot by slot in the 24-slot time-multiplexed order, with stage alignment (fnum/block/dt1 at stage I, mul at stage II) so the phase generator consumes them directly.
- Sits between the bus interface and the phase generator.

Parameters:
- BUSY_CYCLES, 32, number of clk_en ticks busy stays high after a data write.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  slot-advance enable
- cpu_din  in  8  write data
- cpu_addr  in  2  bit0: 0 = address, 1 = data; bit1: part (0 = I, 1 = II)
- cpu_wr  in  1  single-clk write strobe
- busy  out  1  write-busy flag
- slot  out  5  current slot index 0..23 (stage I)
- ch3_mode  out  1  channel-3 special mode flag (reg 0x27 bit6)
- fnum_I  out  11  frequency number for current slot
- block_I  out  3  octave for current slot
- dt1_I  out  3  detune for current slot
- mul_II  out  4  multiplier, one clk_en later than the slot it belongs to

Behaviour:
- Reset (async, rst_n=0): all storage, latches, address register, busy, slot, ch3_mode and all outputs go to 0. Reset mid-write discards the pending write.

Address and data writes:
- Address write (cpu_wr & ~cpu_addr[0]) stores cpu_din and part=cpu_addr[1].
- Data write (cpu_wr & cpu_addr[0]) is decoded against the stored address and part; the data part bit must match the stored part, otherwise the write is ignored.
- Data writes commit on the clk edge after the strobe, independent of clk_en.
- ch = part*3 + addr[1:0]; addr[1:0]=3 is ignored for all channel registers.

Register map:
- 0x30-0x3F: op = addr[3:2] (0:S1, 1:S3, 2:S2, 3:S4). dt1 = din[6:4], mul = din[3:0].
- 0xA4-0xA6: load the shared high latch with {block=din[5:3], fnum_hi=din[2:0]}; storage is unchanged.
- 0xA0-0xA2: commit fnum = {latch fnum_hi, din}, block = latch block for ch.
- 0xAC-0xAE / 0xA8-0xAA: same pattern with a separate CH3 latch, part I only.
  - 0xA9 targets S1, 0xA8 targets S3, 0xAA targets S2.
  - Part II writes to this range are ignored.
- 0x27: part I only; ch3_mode = din[6]. Other bits are ignored.
- All other addresses are ignored with no side effects, except that busy still fires.

Busy:
- Any data write sets busy=1 and loads a counter with BUSY_CYCLES.
- The counter decrements on clk_en; busy drops when it reaches 0.
- A write while busy is still accepted and restarts the counter.

Slot sequencing:
- slot increments on clk_en and wraps 23→0.
- slot = op*6 + ch, so ops run in S1,S3,S2,S4 order with ch 0..5 inside each op.
- fnum_I, block_I, dt1_I are registered: they update on the same clk_en edge as slot and reflect slot's storage.
- Channel 2 with ch3_mode=1 and op in {S1,S3,S2} takes fnum/block from the CH3 per-operator storage. S4 always uses normal channel-2 storage.
- mul_II is the mul of the previous slot, registered on clk_en.

Simultaneous write and read:
- If a commit hits the entry currently being read on the same edge, the output shows the old value.
- The new value appears on the next visit to that slot.

Decomposition:
- Shared package (jt12_pkg): constants for register addresses (0x27, 0x30, 0xA0, 0xA4, 0xA8, 0xAC), slot count 24, channel count 6, operator order encoding.
- One natural sub-module, jt12_freq_regs: write decoder plus storage arrays and latches.
- The top level holds the slot counter, busy counter and output pipeline.

Test Plan:
1. Reset, then run 24 clk_en: slot cycles 0..23→0; all outputs 0; busy 0.
2. Part I write 0xA4←0x22, then 0xA0←0x55: on slot 0 (S1,ch0), fnum_I=0x255 and block_I=4. Before the 0xA0 write, fnum_I stays 0. busy high exactly 32 clk_en after each data write.
3. Part II write 0x31←0x73 (ch4, S1): at slot 4, dt1_I=7. At slot 5's clk_en edge, mul_II=3. Write 0x33←0xFF: no storage change.
4. Channel 3 special mode:
   - Write 0x27←0x40, 0xAD←0x0B, 0xA9←0x10, then 0xA6←0x08, 0xA2←0x20.
   - Slot 2 (S1,ch2): fnum_I=0x310, block_I=1.
   - Slot 20 (S4,ch2): fnum_I=0x020, block_I=1.
   - Clear 0x27: slot 2 shows 0x020.
5. Data write while busy=1 with 5 ticks left: counter restarts to 32. Issue a data write, then assert rst_n=0 on the next clk before commit: storage stays 0, busy 0.
6. Commit on the same edge that slot 6's value is registered: old value output at slot 6 this pass, new value on the following pass.
